// File: rtl/sntc_ldpc_syndrome_sched.sv
// sntc_ldpc_syndrome_sched
//   Schedules a hard-decision LDPC decode loop. It presents a word to an
//   external syndrome datapath, waits for the datapath latency, and checks
//   the returned syndrome. A zero syndrome finishes the decode. A nonzero
//   syndrome hands the word to an external bit-flip engine and then
//   re-checks the result. After MAX_ITER flips the decode finishes and is
//   reported as failed.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    codeword input handshake, in_cword = received word
//   syn_y, syn_clr       word and one-cycle clear pulse to the datapath
//   syn_nr               syndrome returned by the datapath
//   syn_valid_cword      datapath flag: syndrome is all-zero
//   flip_req, flip_syn   request and captured syndrome to the flip engine
//   flip_ack, flip_word  flip engine completion and its updated word
//   out_valid/out_ready  result handshake
//   out_cword            final word
//   out_ok               1 when a zero syndrome was reached
//   out_iter             number of flips performed
//
// Optional feature (macro SNTC_LDPC_SCHED_STATS_EN)
//   Adds the outputs stat_pass and stat_fail. Each is a saturating 16-bit
//   count of delivered results, with out_ok = 1 and 0 respectively.
//   Both counters clear on rst.
module sntc_ldpc_syndrome_sched #(
    parameter int NN       = 'h0d0,
    parameter int MM       = 'h0a8,
    parameter int MAX_ITER = 16,
    parameter int SYN_LAT  = 1,
    localparam int ITW     = $clog2(MAX_ITER + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [NN-1:0]  in_cword,
    output logic [NN-1:0]  syn_y,
    output logic           syn_clr,
    input  logic [MM-1:0]  syn_nr,
    input  logic           syn_valid_cword,
    output logic           flip_req,
    output logic [MM-1:0]  flip_syn,
    input  logic           flip_ack,
    input  logic [NN-1:0]  flip_word,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [NN-1:0]  out_cword,
    output logic           out_ok,
    output logic [ITW-1:0] out_iter
`ifdef SNTC_LDPC_SCHED_STATS_EN
    ,
    output logic [15:0]    stat_pass,
    output logic [15:0]    stat_fail
`endif
);

    typedef enum logic [2:0] {IDLE, WAIT, CHECK, FLIP, DONE} state_t;

    // WAIT counts down to zero, so loading SYN_LAT-1 gives SYN_LAT cycles.
    localparam logic [2:0] WAIT_LOAD = 3'(SYN_LAT - 1);

    state_t         state;
    logic [NN-1:0]  word_reg;
    logic [ITW-1:0] iter;
    logic [2:0]     wait_cnt;

    // The word register drives the datapath, the result bus, and the
    // iteration count directly. These outputs are therefore stable
    // throughout DONE.
    assign syn_y     = word_reg;
    assign out_cword = word_reg;
    assign out_iter  = iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_reg <= '0;
            iter     <= '0;
            wait_cnt <= '0;
            in_ready <= 1'b1;
            syn_clr  <= 1'b0;
            flip_req <= 1'b0;
            flip_syn <= '0;
            out_valid <= 1'b0;
            out_ok   <= 1'b0;
        end else begin
            syn_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        word_reg <= in_cword;
                        iter     <= '0;
                        syn_clr  <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        in_ready <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                CHECK: begin
                    if (syn_valid_cword) begin
                        out_ok    <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (iter == ITW'(MAX_ITER)) begin
                        out_ok    <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        flip_syn <= syn_nr;
                        flip_req <= 1'b1;
                        state    <= FLIP;
                    end
                end
                FLIP: begin
                    if (flip_ack) begin
                        word_reg <= flip_word;
                        iter     <= iter + 1'b1;
                        syn_clr  <= 1'b1;
                        flip_req <= 1'b0;
                        wait_cnt <= WAIT_LOAD;
                        state    <= WAIT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SNTC_LDPC_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pass <= '0;
            stat_fail <= '0;
        end else if (state == DONE && out_ready) begin
            if (out_ok) begin
                if (stat_pass != 16'hFFFF) stat_pass <= stat_pass + 16'd1;
            end else begin
                if (stat_fail != 16'hFFFF) stat_fail <= stat_fail + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sntc_ldpc_syndrome_sched.sv
// Testbench for sntc_ldpc_syndrome_sched.
//
// The bench emulates both external blocks:
//   - Syndrome datapath: it returns garbage until SYN_LAT cycles after
//     syn_clr, then returns the real syndrome of syn_y.
//   - Flip engine: it answers flip_req after a fixed or random delay, and
//     also drives spurious acknowledges while no request is pending.
// A transaction-level model checks every DUT output on every cycle.
// Directed scenarios add hand-computed expectations.
module tb_sntc_ldpc_syndrome_sched;

    localparam int NN       = 32;
    localparam int MM       = 12;
    localparam int MAX_ITER = 4;
    localparam int SYN_LAT  = 1;
    localparam int ITW      = $clog2(MAX_ITER + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [NN-1:0]  in_cword;
    logic [NN-1:0]  syn_y;
    logic           syn_clr;
    logic [MM-1:0]  syn_nr;
    logic           syn_valid_cword;
    logic           flip_req;
    logic [MM-1:0]  flip_syn;
    logic           flip_ack;
    logic [NN-1:0]  flip_word;
    logic           out_valid;
    logic           out_ready;
    logic [NN-1:0]  out_cword;
    logic           out_ok;
    logic [ITW-1:0] out_iter;
`ifdef SNTC_LDPC_SCHED_STATS_EN
    logic [15:0]    stat_pass;
    logic [15:0]    stat_fail;
`endif

    always #5 clk = ~clk;

    sntc_ldpc_syndrome_sched #(
        .NN(NN), .MM(MM), .MAX_ITER(MAX_ITER), .SYN_LAT(SYN_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_cword(in_cword),
        .syn_y(syn_y), .syn_clr(syn_clr), .syn_nr(syn_nr),
        .syn_valid_cword(syn_valid_cword),
        .flip_req(flip_req), .flip_syn(flip_syn),
        .flip_ack(flip_ack), .flip_word(flip_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cword(out_cword), .out_ok(out_ok), .out_iter(out_iter)
`ifdef SNTC_LDPC_SCHED_STATS_EN
        , .stat_pass(stat_pass), .stat_fail(stat_fail)
`endif
    );

    // Toy parity check: the syndrome is the XOR of the low and high MM bits.
    function automatic logic [MM-1:0] syn_of(input logic [NN-1:0] w);
        return w[MM-1:0] ^ w[NN-1:NN-MM];
    endfunction

    function automatic logic [NN-1:0] mk_valid(input logic [NN-1:0] w);
        logic [NN-1:0] r;
        r = w;
        r[NN-1:NN-MM] = w[MM-1:0];
        return r;
    endfunction

    function automatic logic [NN-1:0] mk_invalid(input logic [NN-1:0] w);
        logic [NN-1:0] r;
        r = w;
        r[NN-1:NN-MM] = w[MM-1:0] ^ MM'(1);
        return r;
    endfunction

    // ---------------- syndrome datapath emulation ----------------
    logic [3:0]  dp_age  = '0;
    logic [MM:0] dp_junk = '0;
    logic        dp_ready;

    always @(posedge clk) begin
        if (rst)                  dp_age <= '0;
        else if (syn_clr)         dp_age <= 4'd1;
        else if (dp_age != 4'hF)  dp_age <= dp_age + 4'd1;
        dp_junk <= (MM+1)'($urandom);
    end

    assign dp_ready        = (dp_age >= 4'(SYN_LAT));
    assign syn_nr          = dp_ready ? syn_of(syn_y) : dp_junk[MM-1:0];
    assign syn_valid_cword = dp_ready ? (syn_of(syn_y) == '0) : dp_junk[MM];

    // ---------------- behavioural model + per-cycle compare ----------------
    int m_total = 0;
    int m_pass  = 0;

    task automatic chk_m(input string name, input logic [63:0] act, input logic [63:0] exp);
        m_total++;
        if (act === exp) m_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    initial begin : model
        bit            m_valid = 1'b0;
        bit            m_idle  = 1'b1;
        bit            m_flip  = 1'b0;
        bit            m_done  = 1'b0;
        bit            m_ok    = 1'b0;
        bit            m_clr   = 1'b0;
        bit            m_clr_n;
        logic [NN-1:0] m_word  = '0;
        logic [MM-1:0] m_fsyn  = '0;
        logic [MM-1:0] s;
        int            m_iter  = 0;
        int            m_cyc   = 0;
        int            m_chk   = -1;
        logic [15:0]   m_sp    = '0;
        logic [15:0]   m_sf    = '0;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk_m("in_ready",  in_ready,  m_idle);
                chk_m("syn_y",     syn_y,     m_word);
                chk_m("syn_clr",   syn_clr,   m_clr);
                chk_m("flip_req",  flip_req,  m_flip);
                chk_m("flip_syn",  flip_syn,  m_fsyn);
                chk_m("out_valid", out_valid, m_done);
                if (m_done) begin
                    chk_m("out_cword", out_cword, m_word);
                    chk_m("out_ok",    out_ok,    m_ok);
                    chk_m("out_iter",  out_iter,  m_iter);
                end
`ifdef SNTC_LDPC_SCHED_STATS_EN
                chk_m("stat_pass", stat_pass, m_sp);
                chk_m("stat_fail", stat_fail, m_sf);
`endif
            end
            // Advance the model with the inputs the next edge will sample.
            m_clr_n = 1'b0;
            if (rst) begin
                m_valid = 1'b1; m_idle = 1'b1; m_flip = 1'b0; m_done = 1'b0;
                m_ok = 1'b0; m_word = '0; m_fsyn = '0; m_iter = 0; m_chk = -1;
                m_sp = '0; m_sf = '0;
            end else if (m_valid) begin
                if (m_idle) begin
                    if (in_valid) begin
                        m_idle = 1'b0; m_word = in_cword; m_iter = 0;
                        m_clr_n = 1'b1; m_chk = m_cyc + SYN_LAT + 1;
                    end
                end else if (m_done) begin
                    if (out_ready) begin
                        m_done = 1'b0; m_idle = 1'b1;
                        if (m_ok) begin if (m_sp != 16'hFFFF) m_sp = m_sp + 16'd1; end
                        else      begin if (m_sf != 16'hFFFF) m_sf = m_sf + 16'd1; end
                    end
                end else if (m_flip) begin
                    if (flip_ack) begin
                        m_word = flip_word; m_iter++; m_flip = 1'b0;
                        m_clr_n = 1'b1; m_chk = m_cyc + SYN_LAT + 1;
                    end
                end else if (m_cyc == m_chk) begin
                    s = syn_of(m_word);
                    if (s == '0) begin m_done = 1'b1; m_ok = 1'b1; end
                    else if (m_iter == MAX_ITER) begin m_done = 1'b1; m_ok = 1'b0; end
                    else begin m_flip = 1'b1; m_fsyn = s; end
                end
            end
            m_clr = m_clr_n;
            m_cyc++;
        end
    end

    // ---------------- driver, flip engine, directed checks ----------------
    int d_total = 0;
    int d_pass  = 0;
    bit fe_on, fe_spur;
    int fe_mode, fe_delay, fe_wait, fe_n;

    task automatic chk_d(input string name, input logic [63:0] act, input logic [63:0] exp);
        d_total++;
        if (act === exp) d_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic next_word(output logic [NN-1:0] w);
        w = $urandom;
        case (fe_mode)
            0: if ($urandom_range(0, 2) == 0) w = mk_valid(w);
            1: w = mk_invalid(w);
            default: begin
                w = (fe_n == 0) ? 32'h0000_0001 : 32'h5A5F_F5A5;
                fe_n++;
            end
        endcase
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        flip_ack = 1'b0;
        if (fe_on && flip_req) begin
            if (fe_wait < 0) fe_wait = (fe_delay < 0) ? int'($urandom_range(0, 4)) : fe_delay;
            if (fe_wait == 0) begin
                flip_ack = 1'b1;
                next_word(flip_word);
                fe_wait = -1;
            end else begin
                fe_wait--;
            end
        end else if (fe_spur && $urandom_range(0, 5) == 0) begin
            flip_ack  = 1'b1;
            flip_word = $urandom;
        end
    endtask

    task automatic run_to_done(input logic [NN-1:0] w, output int ticks, output int eps);
        bit prev;
        prev = 1'b0; ticks = 0; eps = 0;
        in_valid = 1'b1; in_cword = w;
        while (!out_valid && ticks < 300) begin
            tick();
            in_valid = 1'b0;
            ticks++;
            if (flip_req && !prev) eps++;
            prev = flip_req;
        end
        if (ticks >= 300) chk_d("done_timeout", 0, 1);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_d("release_in_ready", in_ready, 1);
    endtask

    initial begin : driver
        int t, e, n;
        logic [NN-1:0] w;
        rst = 1'b1; in_valid = 1'b0; in_cword = '0; out_ready = 1'b0;
        flip_ack = 1'b0; flip_word = '0;
        fe_on = 1'b0; fe_spur = 1'b0; fe_mode = 0; fe_delay = 0; fe_wait = -1; fe_n = 0;
        tick(); tick();
        chk_d("rst_in_ready",  in_ready,  1);
        chk_d("rst_out_valid", out_valid, 0);
        chk_d("rst_flip_req",  flip_req,  0);
        chk_d("rst_syn_clr",   syn_clr,   0);
        chk_d("rst_syn_y",     syn_y,     0);
        chk_d("rst_flip_syn",  flip_syn,  0);
        chk_d("rst_out_ok",    out_ok,    0);
        chk_d("rst_out_iter",  out_iter,  0);
        chk_d("rst_out_cword", out_cword, 0);
        rst = 1'b0;
        tick();

        // Clean word: out_valid appears three cycles after the accept cycle.
        w = 32'hABC0_0ABC;
        run_to_done(w, t, e);
        chk_d("clean_latency", t, 3);
        chk_d("clean_no_flip", e, 0);
        chk_d("clean_ok",      out_ok, 1);
        chk_d("clean_iter",    out_iter, 0);
        chk_d("clean_cword",   out_cword, w);
        release_out();

        // Two flips, acknowledged 3 cycles after each request.
        fe_on = 1'b1; fe_mode = 2; fe_delay = 3; fe_wait = -1; fe_n = 0;
        run_to_done(32'h1230_0456, t, e);
        chk_d("two_flip_eps",   e, 2);
        chk_d("two_flip_ok",    out_ok, 1);
        chk_d("two_flip_iter",  out_iter, 2);
        chk_d("two_flip_cword", out_cword, 32'h5A5F_F5A5);
        release_out();

        // Syndrome never reaches zero, so the decode exhausts MAX_ITER flips.
        fe_mode = 1; fe_delay = -1; fe_wait = -1;
        run_to_done(32'h0000_0F00, t, e);
        chk_d("max_iter_eps",  e, 4);
        chk_d("max_iter_ok",   out_ok, 0);
        chk_d("max_iter_iter", out_iter, 4);
        release_out();

        // Downstream stalls in DONE while new words are offered.
        w = 32'h7770_0777;
        run_to_done(w, t, e);
        for (int i = 0; i < 10; i++) begin
            chk_d("stall_ctrl",  {out_valid, in_ready, out_ok, out_iter}, {1'b1, 1'b0, 1'b1, 3'd0});
            chk_d("stall_cword", out_cword, w);
            in_valid = 1'b1; in_cword = $urandom;
            tick();
        end
        chk_d("stall_ctrl_last", {out_valid, in_ready}, 2'b10);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_d("stall_release", {out_valid, in_ready}, 2'b01);

        // Reset arrives in the same cycle as the flip acknowledge.
        fe_on = 1'b0; fe_spur = 1'b0; fe_wait = -1;
        in_valid = 1'b1; in_cword = 32'h0000_0F00;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!flip_req && n < 50) begin tick(); n++; end
        chk_d("rst_flip_seen", flip_req, 1);
        rst = 1'b1; flip_ack = 1'b1; flip_word = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        chk_d("rstack_flip_req", flip_req, 0);
        chk_d("rstack_in_ready", in_ready, 1);
        chk_d("rstack_syn_y",    syn_y, 0);
        chk_d("rstack_valid",    out_valid, 0);
        chk_d("rstack_flip_syn", flip_syn, 0);
        tick();

        // Random traffic; the model checks every cycle.
        fe_on = 1'b1; fe_spur = 1'b1; fe_mode = 0; fe_delay = -1; fe_wait = -1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            in_valid = 1'($urandom_range(0, 1));
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w = mk_valid(w);
            in_cword  = w;
            out_ready = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        tick(); tick();

        $display("%0d/%0d checks passed", d_pass + m_pass, d_total + m_total);
        $finish;
    end

endmodule

// File: doc/sntc_ldpc_syndrome_sched.md
SNTC_LDPC_SYNDROME_SCHED -- requirements
Module: sntc_ldpc_syndrome_sched

Interface
REQ-001 SHALL have parameter NN, default 'h0d0, meaning codeword length in bits.
REQ-002 SHALL have parameter MM, default 'h0a8, meaning syndrome length in bits.
REQ-003 SHALL have parameter MAX_ITER, default 16, meaning the maximum number of flip iterations, legal range 1..255.
REQ-004 SHALL have parameter SYN_LAT, default 1, meaning the syndrome datapath latency in cycles, legal range 1..7.
REQ-005 SHALL have localparam ITW = $clog2(MAX_ITER+1), meaning the iteration count width.
REQ-006 Port: clk  input  1  clock; all logic is on its rising edge.
REQ-007 Port: rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-008 Port: in_valid  input  1  new codeword offered.
REQ-009 Port: in_ready  output  1  the scheduler accepts a codeword.
REQ-010 Port: in_cword  input  NN  received hard-decision word.
REQ-011 Port: syn_y  output  NN  word driven to the syndrome datapath y_nr_in.
REQ-012 Port: syn_clr  output  1  one-cycle clear pulse to the syndrome datapath.
REQ-013 Port: syn_nr  input  MM  syndrome returned by the datapath.
REQ-014 Port: syn_valid_cword  input  1  all-zero syndrome flag from the datapath.
REQ-015 Port: flip_req  output  1  request to the external bit-flip engine.
REQ-016 Port: flip_syn  output  MM  syndrome captured for the flip engine.
REQ-017 Port: flip_ack  input  1  flip engine done; flip_word is valid.
REQ-018 Port: flip_word  input  NN  updated word from the flip engine.
REQ-019 Port: out_valid  output  1  result available.
REQ-020 Port: out_ready  input  1  downstream accepts the result.
REQ-021 Port: out_cword  output  NN  final word.
REQ-022 Port: out_ok  output  1  1 = zero syndrome reached.
REQ-023 Port: out_iter  output  ITW  number of flips performed.

Function
REQ-024 FSM SHALL have states IDLE, WAIT, CHECK, FLIP and DONE.
REQ-025 in_ready SHALL be 1 only in IDLE.
- Accept occurs when in_valid & in_ready: word_reg <= in_cword, iter <= 0, syn_clr = 1 for that cycle, next state WAIT.
REQ-026 syn_y SHALL equal word_reg at all times.
REQ-027 WAIT SHALL last exactly SYN_LAT cycles, counted by a down-counter loaded on entry; then the FSM goes to CHECK.
REQ-028 CHECK SHALL sample syn_valid_cword and syn_nr in one cycle, then transition as follows:
- valid -> DONE with ok=1;
- else if iter == MAX_ITER -> DONE with ok=0;
- else -> FLIP, with flip_syn <= syn_nr.
REQ-029 FLIP SHALL hold flip_req = 1 until the cycle in which flip_ack = 1. On that edge: word_reg <= flip_word, iter <= iter+1, syn_clr pulses, next state WAIT. flip_ack outside FLIP SHALL be ignored.
REQ-030 DONE SHALL hold out_valid = 1 with out_cword = word_reg, out_ok and out_iter stable until out_ready = 1; the FSM then returns to IDLE on the next edge.
REQ-031 Latency for a clean word accepted at edge k: out_valid SHALL first be high in cycle k+SYN_LAT+2.
REQ-032 iter SHALL never exceed MAX_ITER; no wrap.
REQ-033 out_ready in states other than DONE SHALL have no effect; in_valid outside IDLE SHALL be ignored, with no input buffering.

Reset
REQ-034 When rst = 1 at an edge, the block SHALL enter IDLE regardless of state, including mid-FLIP and mid-WAIT, and abandon any pending request.
REQ-035 Reset values SHALL be:
- in_ready = 1;
- out_valid = 0, out_ok = 0, out_iter = 0, out_cword = 0;
- flip_req = 0, flip_syn = 0;
- syn_clr = 0, syn_y = 0.
REQ-036 rst SHALL take priority over every simultaneous handshake event.

Configuration
REQ-037 Macro SNTC_LDPC_SCHED_STATS_EN: when defined, the block SHALL add outputs stat_pass[15:0] and stat_fail[15:0]. They increment on each DONE->IDLE transition with out_ok = 1 and 0 respectively, saturate at 16'hFFFF, and clear on rst.
REQ-038 When SNTC_LDPC_SCHED_STATS_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Clean word, SYN_LAT=1, accept at cycle 0, syn_valid_cword=1 -> out_valid in cycle 3, out_ok=1, out_iter=0, flip_req never asserted.
REQ-040 Word needing 2 flips, flip_ack returned 3 cycles after each flip_req -> exactly 2 flip_req episodes, then out_ok=1, out_iter=2, out_cword = last flip_word.
REQ-041 Syndrome never zero, MAX_ITER=4 -> exactly 4 flips, then out_ok=0, out_iter=4; flip_syn equals syn_nr sampled in each CHECK.
REQ-042 out_ready held 0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; accepted on cycle 11, in_ready=1 next cycle.
REQ-043 rst asserted while flip_req=1 and flip_ack=1 in the same cycle -> next cycle IDLE, flip_req=0, word_reg not updated, stats unchanged.
REQ-044 With SNTC_LDPC_SCHED_STATS_EN defined, 3 passes and 2 fails -> stat_pass=3, stat_fail=2; stat_pass preloaded at 16'hFFFF plus one more pass -> remains 16'hFFFF.
